// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers hex digits from a multiplexed 7-segment bus.
// A {digit_en, segment} sample is committed only after it has been seen
// unchanged for STABLE_CYCLES consecutive clocks.
module seg_scan_decoder #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [6:0]              i_segment,
    input  logic [NUM_DIGITS-1:0]   i_digit_en,
    input  logic                    i_clear,
    output logic [4*NUM_DIGITS-1:0] o_hex,
    output logic [NUM_DIGITS-1:0]   o_digit_valid,
    output logic                    o_frame_valid,
    output logic                    o_update,
    output logic                    o_error
);

    localparam int unsigned RUN_W    = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned SAMPLE_W = NUM_DIGITS + 7;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);
    localparam logic [RUN_W-1:0] RUN_PRE = RUN_W'(STABLE_CYCLES - 1);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    logic [SAMPLE_W-1:0]   r_sample;
    logic [RUN_W-1:0]      r_run;

    logic [SAMPLE_W-1:0]   w_in;
    logic [NUM_DIGITS-1:0] w_en;
    logic [6:0]            w_seg;
    logic                  w_same;
    logic                  w_commit;
    logic                  w_en_zero;
    logic                  w_en_onehot;
    logic                  w_dec_ok;
    logic [3:0]            w_nib;

    // Inverse of the display encoding: {valid, nibble}
    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'h7E:   res = 5'h10;
            7'h30:   res = 5'h11;
            7'h6D:   res = 5'h12;
            7'h79:   res = 5'h13;
            7'h33:   res = 5'h14;
            7'h5B:   res = 5'h15;
            7'h5F:   res = 5'h16;
            7'h70:   res = 5'h17;
            7'h7F:   res = 5'h18;
            7'h7B:   res = 5'h19;
            7'h77:   res = 5'h1A;
            7'h1F:   res = 5'h1B;
            7'h4E:   res = 5'h1C;
            7'h3D:   res = 5'h1D;
            7'h4F:   res = 5'h1E;
            7'h47:   res = 5'h1F;
            default: res = 5'h00;
        endcase
        return res;
    endfunction

    assign w_in        = {i_digit_en, i_segment};
    assign w_en        = r_sample[SAMPLE_W-1:7];
    assign w_seg       = r_sample[6:0];
    assign w_same      = (w_in == r_sample);
    // Commit exactly on the run-count transition into saturation
    assign w_commit    = !i_clear && w_same && (r_run == RUN_PRE);
    assign w_en_zero   = (w_en == '0);
    assign w_en_onehot = !w_en_zero && ((w_en & (w_en - NUM_DIGITS'(1))) == '0);
    assign {w_dec_ok, w_nib} = decode(w_seg);

    assign o_frame_valid = &o_digit_valid;

    // Stability tracking, slot capture and result pulses
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sample      <= '0;
            r_run         <= '0;
            o_hex         <= '0;
            o_digit_valid <= '0;
            o_update      <= 1'b0;
            o_error       <= 1'b0;
        end else begin
            o_update <= 1'b0;
            o_error  <= 1'b0;
            if (i_clear) begin
                r_run         <= '0;
                o_hex         <= '0;
                o_digit_valid <= '0;
            end else begin
                if (w_same) begin
                    if (r_run != RUN_MAX) begin
                        r_run <= r_run + RUN_ONE;
                    end
                end else begin
                    r_sample <= w_in;
                    r_run    <= RUN_ONE;
                end
                if (w_commit) begin
                    if (w_en_onehot) begin
                        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
                            if (w_en[k]) begin
                                if (w_dec_ok) begin
                                    o_hex[4*k +: 4]  <= w_nib;
                                    o_digit_valid[k] <= 1'b1;
                                end else begin
                                    o_digit_valid[k] <= 1'b0;
                                end
                            end
                        end
                        if (w_dec_ok) begin
                            o_update <= 1'b1;
                        end else begin
                            o_error <= 1'b1;
                        end
                    end else if (!w_en_zero) begin
                        o_error <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomized + directed bench for seg_scan_decoder against a sample-history model.
module tb_seg_scan_decoder;

    localparam int ND = 4;
    localparam int S  = 8;
    localparam int SW = ND + 7;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [6:0]      seg = '0;
    logic [ND-1:0]   en  = '0;
    logic            clr = 1'b0;
    logic [4*ND-1:0] o_hex;
    logic [ND-1:0]   o_digit_valid;
    logic            o_frame_valid;
    logic            o_update;
    logic            o_error;

    seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
        .i_clk(clk), .i_rst(rst), .i_segment(seg), .i_digit_en(en),
        .i_clear(clr), .o_hex(o_hex), .o_digit_valid(o_digit_valid),
        .o_frame_valid(o_frame_valid), .o_update(o_update), .o_error(o_error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int n_upd = 0;
    int n_err = 0;

    // Display encoding, index = nibble
    logic [6:0] tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Model state: history of samples since the last clear/reset
    logic [SW-1:0]   q [$];
    logic [4*ND-1:0] m_hex = '0;
    logic [ND-1:0]   m_val = '0;
    logic            m_upd = 1'b0;
    logic            m_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_hex = '0; m_val = '0; m_upd = 1'b0; m_err = 1'b0;
    endtask

    // One clock edge: commit when the last S samples match and the run just reached S
    task automatic model_step(input logic [ND-1:0] e, input logic [6:0] s, input logic c);
        logic [SW-1:0] smp;
        bit commit;
        int nib;
        m_upd = 1'b0; m_err = 1'b0;
        if (c) begin
            q.delete(); m_hex = '0; m_val = '0;
            return;
        end
        smp = {e, s};
        q.push_back(smp);
        if (q.size() > S + 1) void'(q.pop_front());
        commit = (q.size() >= S);
        for (int i = q.size() - S; commit && i < q.size(); i++)
            if (q[i] != smp) commit = 0;
        if (commit && q.size() == S + 1 && q[0] == smp) commit = 0;
        if (!commit) return;
        if ($countones(e) > 1) begin
            m_err = 1'b1;
        end else if ($countones(e) == 1) begin
            nib = -1;
            for (int n = 0; n < 16; n++) if (tbl[n] == s) nib = n;
            for (int k = 0; k < ND; k++) begin
                if (e[k]) begin
                    if (nib >= 0) begin
                        m_hex[4*k +: 4] = 4'(nib);
                        m_val[k] = 1'b1;
                        m_upd = 1'b1;
                    end else begin
                        m_val[k] = 1'b0;
                        m_err = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic tick(input logic [ND-1:0] e, input logic [6:0] s, input logic c);
        en = e; seg = s; clr = c;
        @(posedge clk);
        model_step(e, s, c);
        #1;
        n_upd += int'(o_update);
        n_err += int'(o_error);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("hex", 32'(o_hex), 32'(m_hex));
        chk("digit_valid", 32'(o_digit_valid), 32'(m_val));
        chk("frame_valid", 32'(o_frame_valid), 32'(&m_val));
        chk("update", 32'(o_update), 32'(m_upd));
        chk("error", 32'(o_error), 32'(m_err));
        chk("pulse_overlap", 32'(o_update & o_error), 32'd0);
    end

    initial begin
        logic [ND-1:0] re;
        logic [6:0]    rs;
        int            len;

        // 1: basic capture and single pulse
        do_reset();
        chk("reset_hex", 32'(o_hex), 32'd0);
        n_upd = 0; n_err = 0;
        repeat (7) tick(4'b0001, 7'h6D, 1'b0);
        chk("t1_no_early_update", 32'(n_upd), 32'd0);
        tick(4'b0001, 7'h6D, 1'b0);
        chk("t1_nibble", 32'(o_hex[3:0]), 32'd2);
        chk("t1_valid", 32'(o_digit_valid), 32'b0001);
        chk("t1_update_pulse", 32'(o_update), 32'd1);
        n_upd = 0;
        repeat (40) tick(4'b0001, 7'h6D, 1'b0);
        chk("t1_hold_no_pulse", 32'(n_upd + n_err), 32'd0);

        // 2: glitch rejection
        n_upd = 0; n_err = 0;
        repeat (7) tick(4'b0100, 7'h30, 1'b0);
        repeat (7) tick(4'b0100, 7'h00, 1'b0);
        chk("t2_err_not_early", 32'(n_err), 32'd0);
        tick(4'b0100, 7'h00, 1'b0);
        chk("t2_err_once", 32'(n_err), 32'd1);
        chk("t2_no_update", 32'(n_upd), 32'd0);
        chk("t2_valid_kept", 32'(o_digit_valid), 32'b0001);

        // 3: invalid pattern invalidates slot but keeps nibble
        repeat (8) tick(4'b0010, 7'h77, 1'b0);
        chk("t3_a_captured", 32'(o_hex[7:4]), 32'hA);
        n_err = 0;
        repeat (8) tick(4'b0010, 7'h01, 1'b0);
        chk("t3_err", 32'(n_err), 32'd1);
        chk("t3_valid1_low", 32'(o_digit_valid[1]), 32'd0);
        chk("t3_nibble_kept", 32'(o_hex[7:4]), 32'hA);

        // 4: full frame scan
        tick(4'b0000, 7'h00, 1'b1);
        n_upd = 0;
        for (int k = 0; k < ND; k++) begin
            re = ND'(1) << k;
            repeat (10) tick(re, tbl[k + 1], 1'b0);
            repeat (2) tick(4'b0000, 7'h00, 1'b0);
        end
        chk("t4_hex", 32'(o_hex), 32'h4321);
        chk("t4_frame", 32'(o_frame_valid), 32'd1);
        chk("t4_updates", 32'(n_upd), 32'd4);

        // 5: multi-hot and blanking
        n_upd = 0; n_err = 0;
        repeat (50) tick(4'b0011, 7'h7E, 1'b0);
        chk("t5_multihot_err", 32'(n_err), 32'd1);
        chk("t5_slots_kept", 32'(o_hex), 32'h4321);
        n_err = 0;
        repeat (50) tick(4'b0000, 7'h7E, 1'b0);
        chk("t5_blank_quiet", 32'(n_upd + n_err), 32'd0);

        // 6: clear on commit edge, then reset mid-run
        tick(4'b0000, 7'h00, 1'b1);
        n_upd = 0; n_err = 0;
        repeat (7) tick(4'b0001, 7'h30, 1'b0);
        tick(4'b0001, 7'h30, 1'b1);
        chk("t6_clear_suppress", 32'(n_upd + n_err), 32'd0);
        chk("t6_valid_zero", 32'(o_digit_valid), 32'd0);
        repeat (7) tick(4'b0001, 7'h30, 1'b0);
        chk("t6_fresh_not_early", 32'(n_upd), 32'd0);
        tick(4'b0001, 7'h30, 1'b0);
        chk("t6_fresh_commit", 32'(n_upd), 32'd1);
        repeat (5) tick(4'b0010, 7'h6D, 1'b0);
        do_reset();
        chk("t6_reset_valid", 32'(o_digit_valid), 32'd0);
        chk("t6_reset_hex", 32'(o_hex), 32'd0);
        n_upd = 0;
        repeat (7) tick(4'b0010, 7'h6D, 1'b0);
        chk("t6_reset_not_early", 32'(n_upd), 32'd0);
        tick(4'b0010, 7'h6D, 1'b0);
        chk("t6_reset_commit", 32'(n_upd), 32'd1);

        // Randomized bursts of held samples with glitches, clears and resets
        repeat (400) begin
            len = $urandom_range(1, 12);
            case ($urandom_range(0, 9))
                0:       re = ND'($urandom_range(0, (1 << ND) - 1));
                1:       re = '0;
                default: re = ND'(1) << $urandom_range(0, ND - 1);
            endcase
            if ($urandom_range(0, 4) == 0) rs = 7'($urandom_range(0, 127));
            else rs = tbl[$urandom_range(0, 15)];
            repeat (len) tick(re, rs, ($urandom_range(0, 49) == 0));
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Reads a multiplexed 7-segment display bus: one-hot digit enables plus a shared active-high segment field. For each digit it recovers the 4-bit hex value from the segment pattern, the inverse of the display encoding. It sits on the display side of the UART datapath as a loop-back/self-check monitor. Inputs are accepted only after they have been stable for a programmable number of clocks, so scan transitions and glitches are rejected.

## Interface
- `NUM_DIGITS`, default 4: number of multiplexed digits; range 1–8.
- `STABLE_CYCLES`, default 8: consecutive identical samples required before commit; range 2–255.
- `i_clk`, in, 1: sole clock; all state updates on the rising edge.
- `i_rst`, in, 1: asynchronous reset, active-high.
- `i_segment`, in, 7: segment field; bit 6 = A, bit 0 = G; 1 = lit.
- `i_digit_en`, in, `NUM_DIGITS`: digit enables, active-high, expected one-hot.
- `i_clear`, in, 1: synchronous clear of captured digits and the run counter.
- `o_hex`, out, 4×`NUM_DIGITS`: decoded nibbles; digit k occupies bits [4k+3:4k].
- `o_digit_valid`, out, `NUM_DIGITS`: bit k = 1 when slot k holds a valid decode.
- `o_frame_valid`, out, 1: AND of all `o_digit_valid` bits; combinational from registers.
- `o_update`, out, 1: one-cycle pulse on each successful commit.
- `o_error`, out, 1: one-cycle pulse on each rejected commit.

## Operation
- **Sample register.** Register `r` holds {`i_digit_en`, `i_segment`}. Run counter `run` is sized to hold `STABLE_CYCLES`.
- **Each edge (no clear).**
  - If the inputs equal `r`: `run <= min(run+1, STABLE_CYCLES)`.
  - Otherwise: `r <= inputs` and `run <= 1`.
- **Commit.** A commit fires on the edge where `run` goes from `STABLE_CYCLES-1` to `STABLE_CYCLES`. It fires at most once per stable run because `run` saturates.
- **Commit actions, using `r`:**
  - Enable field is all-zero (display blanking): no action, no pulse.
  - Enable field is multi-hot: `o_error` pulse; all slots unchanged.
  - Enable field is one-hot (digit k) and the pattern is in the decode table: slot k gets the nibble, `o_digit_valid[k] <= 1`, `o_update` pulse.
  - Enable field is one-hot (digit k) and the pattern is not in the table: `o_digit_valid[k] <= 0`, slot k nibble unchanged, `o_error` pulse.
- **Decode table (pattern → nibble).** 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7, 7F→8, 7B→9, 77→A, 1F→B, 4E→C, 3D→D, 4F→E, 47→F. All other patterns are invalid.
- **`i_clear`.** Sets `o_digit_valid <= 0` and `o_hex <= 0`. Resets `run` to 0; `r` is unchanged, so a fresh run of `STABLE_CYCLES` edges is required. It takes priority over a commit on the same edge, which is suppressed with no pulse.
- **Reset.** While `i_rst` is high: `r=0`, `run=0`, `o_hex=0`, `o_digit_valid=0`, `o_update=0`, `o_error=0`, hence `o_frame_valid=0` (it is 1 only if `NUM_DIGITS` bits are all valid). Reset mid-run discards the partial run.

## Timing
- Inputs constant on edges e1..eS (S = `STABLE_CYCLES`):
  - e1 loads `r` (`run=1`).
  - eS commits.
  - `o_hex`, `o_digit_valid`, `o_update`/`o_error` are visible after eS.
  - Latency = `STABLE_CYCLES` edges from first sample.
- A change on any input bit before eS restarts the count at 1.
- Pulses are exactly one cycle wide; `o_update` and `o_error` are never high together.
- `o_frame_valid` follows `o_digit_valid` in the same cycle, with no extra delay.
- Inputs are treated as synchronous to `i_clk`; external synchronizers are the integrator's responsibility.

## Test plan
1. Reset, then `i_digit_en=4'b0001`, `i_segment=7'h6D` for 8 edges → after edge 8: `o_hex[3:0]=2`, `o_digit_valid=4'b0001`, single `o_update` pulse. Hold 40 more edges → no further pulses.
2. Glitch rejection: `7'h30` on digit 2 for 7 edges, then `7'h00` on digit 2 → no `o_update`, `o_digit_valid` unchanged; `o_error` pulses once 8 edges after the change.
3. Invalid pattern: after digit 1 captures `7'h77` (A), apply `7'h01` on digit 1 for 8 edges → `o_error` pulse, `o_digit_valid[1]=0`, `o_hex[7:4]` stays A.
4. Full frame: scan digits 0..3 with 30, 6D, 79, 33 (10 edges each, 2 blank edges between) → `o_hex=16'h4321`; `o_frame_valid` rises the cycle after the digit-3 commit; 4 `o_update` pulses total.
5. Multi-hot `4'b0011` with `7'h7E` for 50 edges → exactly one `o_error` pulse, no slot written. All-zero enable for 50 edges → no pulses.
6. `i_clear` asserted on the commit edge → no pulse, valids stay 0, and a new commit needs 8 further stable edges. Assert `i_rst` for 1 cycle at `run=5` → all outputs 0, and the next commit needs 8 fresh edges.
